// File: rtl/fib_sequencer.sv
// -----------------------------------------------------------------------------
// fib_sequencer
//
// Request-side controller for the fibonacci core. It sweeps an inclusive index
// range n_first..n_last, issues one request per index to the core, waits for
// the result and hands each result (tagged with its index) to downstream logic
// over a valid/ready stream. A per-request watchdog aborts the whole sweep if
// the core stays busy for too long.
//
// Parameters
//   WIDTH    width of indices and results (must match the core)
//   TIMEOUT  maximum WAIT cycles per request before the sweep is aborted (>= 2)
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   run                      one-cycle sweep request (ignored while active)
//   n_first, n_last          inclusive index range, sampled with run
//   fib_start, fib_n         request pulse and index to the core
//   fib_result, fib_busy     result and busy flag from the core
//   out_valid, out_ready     entry handshake
//   out_n, out_result        entry index and value (value is 0 on timeout)
//   out_last, out_timeout    final entry of the sweep / entry made by watchdog
//   active                   sweep in progress
//   done                     one-cycle pulse after the final entry is accepted
//
// Every output is a register; out_ready and fib_busy only steer next-state
// logic, so neither has a combinational path to an output.
// -----------------------------------------------------------------------------
module fib_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [WIDTH-1:0] n_first,
  input  logic [WIDTH-1:0] n_last,
  output logic             fib_start,
  output logic [WIDTH-1:0] fib_n,
  input  logic [WIDTH-1:0] fib_result,
  input  logic             fib_busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_n,
  output logic [WIDTH-1:0] out_result,
  output logic             out_last,
  output logic             out_timeout,
  output logic             active,
  output logic             done
);

  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    EMIT
  } state_t;

  state_t           state;
  state_t           state_d;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] n_last_q;
  logic [WD_W-1:0]  wdog;

  logic             range_ok;
  logic             accept;
  logic             wdog_expire;
  logic             cur_is_last;

  assign range_ok    = (n_first <= n_last);
  assign accept      = out_valid & out_ready;
  assign wdog_expire = (wdog == WD_W'(TIMEOUT - 1));
  // End of range is found by equality before the increment, so a range that
  // ends at the all-ones index never needs cur to wrap.
  assign cur_is_last = (cur == n_last_q);

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (run && range_ok) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = GUARD;
      end
      // The core raises busy on the edge that samples start, so busy is not
      // trustworthy until one cycle after the request.
      GUARD: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (!fib_busy || wdog_expire) begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (accept) begin
          state_d = out_last ? IDLE : ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fib_start   <= 1'b0;
      fib_n       <= '0;
      out_valid   <= 1'b0;
      out_n       <= '0;
      out_result  <= '0;
      out_last    <= 1'b0;
      out_timeout <= 1'b0;
      active      <= 1'b0;
      done        <= 1'b0;
      wdog        <= '0;
    end else begin
      state     <= state_d;
      // Registered from next state so the pulse lines up with the ISSUE cycle.
      fib_start <= (state_d == ISSUE);
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (run) begin
            if (range_ok) begin
              cur      <= n_first;
              n_last_q <= n_last;
              fib_n    <= n_first;
              active   <= 1'b1;
            end else begin
              // Empty range: no request, no entry, just the completion pulse.
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          wdog <= '0;
        end
        GUARD: begin
          wdog <= '0;
        end
        WAIT: begin
          if (!fib_busy) begin
            out_valid   <= 1'b1;
            out_n       <= cur;
            out_result  <= fib_result;
            out_last    <= cur_is_last;
            out_timeout <= 1'b0;
          end else if (wdog_expire) begin
            // Hung core: emit a zero-valued marker entry and end the sweep.
            out_valid   <= 1'b1;
            out_n       <= cur;
            out_result  <= '0;
            out_last    <= 1'b1;
            out_timeout <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        EMIT: begin
          if (accept) begin
            out_valid <= 1'b0;
            if (out_last) begin
              active <= 1'b0;
              done   <= 1'b1;
            end else begin
              cur   <= cur + 1'b1;
              fib_n <= cur + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fib_sequencer.md
# fib_sequencer

Request-side controller for the `fibonacci` core. It drives the core's `start`/`n` inputs and consumes its `result`/`busy` outputs, sweeping a range of indices `n_first..n_last`. Each result is tagged with its index and emitted on a valid/ready stream for downstream logic (UART formatter, LEDs). A watchdog aborts the sweep if the core hangs.

## Interface
- `WIDTH`, 32: width of indices and results; must match the core.
- `TIMEOUT`, 4096: maximum WAIT cycles per request before abort. Must be ≥ 2.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  one-cycle start-of-sweep request; ignored while `active`.
- `n_first`  in  WIDTH  first index; sampled when `run` is accepted.
- `n_last`  in  WIDTH  last index, inclusive; sampled with `n_first`.
- `fib_start`  out  1  one-cycle request pulse to the core.
- `fib_n`  out  WIDTH  index to the core; stable from `fib_start` until the result is captured.
- `fib_result`  in  WIDTH  core result; valid when `fib_busy` is low after a request.
- `fib_busy`  in  1  core busy flag.
- `out_valid`  out  1  result entry available.
- `out_ready`  in  1  downstream accepts the entry on any edge where valid and ready are both high.
- `out_n`  out  WIDTH  index of the entry.
- `out_result`  out  WIDTH  Fibonacci value; 0 on timeout.
- `out_last`  out  1  final entry of the sweep (normal end or abort).
- `out_timeout`  out  1  entry was produced by the watchdog.
- `active`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the final entry is accepted.

## Operation
- States: IDLE, ISSUE, GUARD, WAIT, EMIT.
- **IDLE**
  - `run`=1 and `n_first` ≤ `n_last`: latch the range, set `cur`=`n_first`, go to ISSUE, set `active`.
  - `run`=1 and `n_first` > `n_last`: empty sweep. No request and no entry are produced. Pulse `done` on the next cycle.
- **ISSUE:** `fib_start`=1, `fib_n`=`cur`, watchdog cleared. Go to GUARD.
- **GUARD:** one cycle in which `fib_busy` is ignored. The core raises `busy` on the edge that samples `start`. Go to WAIT.
- **WAIT:** watchdog increments every cycle.
  - `fib_busy`=0: capture `fib_result` into `out_result` and `cur` into `out_n`. Set `out_last` = (`cur`==`n_last`). Go to EMIT.
  - Watchdog reaches TIMEOUT−1 while `fib_busy`=1: set `out_result`=0, `out_timeout`=1, `out_last`=1. Go to EMIT. The sweep is aborted.
- **EMIT:** `out_valid`=1 and entry fields are held until accepted.
  - Accepted with `out_last`=1: go to IDLE, pulse `done`, clear `active`.
  - Accepted with `out_last`=0: `cur`=`cur`+1, go to ISSUE.
  - While stalled, no new request is issued.
- The end of range is detected by equality before increment. With `n_last`=2^WIDTH−1, `cur` never wraps.
- `run` asserted while `active`=1 is dropped. It is not queued.
- `fib_result` is only sampled in WAIT. Changes at other times are ignored.

## Timing
- Reset value of every output is 0. The state returns to IDLE on the edge where `rst`=1, including mid-sweep. The core is not reset by this block.
- Latencies, with `run` sampled at edge k:
  - `fib_start`=1 during cycle k+1 only.
  - GUARD occupies cycle k+2.
  - The earliest capture is edge k+3.
- Entry latency is core latency + 3 cycles. With `out_ready` held high, the next `fib_start` follows 1 cycle after acceptance.
- `out_valid` rises the cycle after capture. It falls the cycle after acceptance.
- `done` is high exactly one cycle. It is coincident with `active` falling.
- All outputs are registered. There is no combinational path from `out_ready` or `fib_busy` to any output.

## Test plan
- **Single index:** reset, then `run` with `n_first`=`n_last`=10 and `out_ready`=1 → one entry `out_n`=10, `out_result`=55, `out_last`=1. `done` pulses once and `fib_start` pulsed once.
- **Sweep 0..15:** 16 entries in order; values 0,1,1,2,3,5,8,13,21,34,55,89,144,233,377,610. Only the final entry has `out_last`=1.
- **Backpressure:** sweep 5..7 with `out_ready` toggled pseudo-randomly → entries 5, 8, 13 with no loss or duplication, and no `fib_start` while `out_valid`=1.
- **Hung core:** model holds `fib_busy`=1 forever, TIMEOUT=16, sweep 3..9 → a single entry `out_n`=3, `out_timeout`=1, `out_result`=0, `out_last`=1, then `done`.
- **Empty range:** `n_first`=8, `n_last`=4 → no `fib_start`, no `out_valid`, `done` pulses one cycle after `run`.
- **Reset and ignored run:** `run` asserted again mid-sweep → ignored. `rst` asserted during WAIT → all outputs 0 next cycle, and a fresh `run` 2..2 yields `out_result`=1.
